// File: rtl/data_mem_responder_if.sv
// Load/store request and response channel between the core MEM stage
// and the data memory responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding byte/half/word load-store responder over a word array.
// Define MISALIGN_TRAP_EN to turn misaligned half/word accesses into errors.
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input logic                 clk1,
  input logic                 rst,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t        state;
  req_t          req_q;
  logic [4:0]    cnt;
  logic          rdy_q, vld_q, err_q;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] widx;
  logic [31:0]   word, ld_data, st_data;
  logic [7:0]    b;
  logic [15:0]   h;
  logic [3:0]    st_be;
  logic          bad, misal, commit, accept;

  assign accept = bus.req_valid & rdy_q;
  // Counter covers the access cycle plus the wait states; commit on its last count.
  assign commit = (state == WAIT) && (cnt == 5'd1);
  assign widx   = req_q.addr[AW+1:2];
  assign word   = mem[widx];

  always_comb begin
    misal = 1'b0;
`ifdef MISALIGN_TRAP_EN
    case (req_q.funct3[1:0])
      2'b01:   misal = req_q.addr[0];
      2'b10:   misal = |req_q.addr[1:0];
      default: misal = 1'b0;
    endcase
`endif
    bad = ({2'b00, req_q.addr[31:2]} >= 32'(DEPTH)) ||
          (req_q.funct3 == 3'b011) || (req_q.funct3 == 3'b110) ||
          (req_q.funct3 == 3'b111) || (req_q.we && req_q.funct3[2]) || misal;
  end

  always_comb begin
    case (req_q.addr[1:0])
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = req_q.addr[1] ? word[31:16] : word[15:0];
    case (req_q.funct3)
      3'b000:  ld_data = {{24{b[7]}}, b};
      3'b100:  ld_data = {24'd0, b};
      3'b001:  ld_data = {{16{h[15]}}, h};
      3'b101:  ld_data = {16'd0, h};
      default: ld_data = word;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the live one.
  always_comb begin
    case (req_q.funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << req_q.addr[1:0];
        st_data = {4{req_q.wdata[7:0]}};
      end
      2'b01: begin
        st_be   = req_q.addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{req_q.wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = req_q.wdata;
      end
    endcase
  end

  always_ff @(posedge clk1) begin
    if (commit && req_q.we && !bad)
      for (int i = 0; i < 4; i++)
        if (st_be[i]) mem[widx][8*i +: 8] <= st_data[8*i +: 8];
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt     <= '0;
      req_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          rdy_q <= 1'b1;
          if (accept) begin
            req_q <= '{we: bus.req_we, funct3: bus.req_funct3,
                       addr: bus.req_addr, wdata: bus.req_wdata};
            cnt   <= 5'(WAIT_CYCLES + 1);
            rdy_q <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (commit) begin
            vld_q   <= 1'b1;
            err_q   <= bad;
            rdata_q <= (bad || req_q.we) ? 32'd0 : ld_data;
            state   <= RESP;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rdy_q   <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          rdy_q <= 1'b0;
          vld_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = rdy_q;
  assign bus.resp_valid = vld_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule
